// File: rtl/v850_pkg.sv
`default_nettype none
// ============================================================================
// Module      : v850_pkg
// Description : Shared types and helpers for the V850 instruction fetch unit:
//               halfword / length types, the MOV imm32 opcode, the
//               instruction-length decoder and PC canonicalisation.
//               Optional macro V850_LONG48_EN enables 48-bit MOV imm32 decode.
// Revision    : 1.0 - initial release
// ============================================================================
package v850_pkg;

    typedef logic [15:0] halfword_t;

    typedef enum logic [1:0] {
        LEN16 = 2'd1,
        LEN32 = 2'd2,
        LEN48 = 2'd3
    } inst_len_t;

    localparam logic [5:0] OPC_MOV_IMM32 = 6'b110001;

    // Instruction length in halfwords, decided from the first halfword only.
    function automatic inst_len_t inst_length(input halfword_t h);
`ifdef V850_LONG48_EN
        if (h[10:5] == OPC_MOV_IMM32 && h[15:11] == 5'd0) begin
            return LEN48;
        end
`endif
        if (h[10:9] == 2'b11) begin
            return LEN32;
        end
        return LEN16;
    endfunction

    // Halfword-aligned PC with bits [31:26] sign-extended from bit 25.
    function automatic logic [31:0] pc_canon(input logic [31:0] pc);
        return {{6{pc[25]}}, pc[25:1], 1'b0};
    endfunction

endpackage
`default_nettype wire

// File: rtl/v850_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module      : v850_fetch_queue
// Description : Halfword circular FIFO for the prefetch queue. Accepts 0/1/2
//               halfwords per cycle, releases 0..3, exposes the three head
//               entries and the occupancy, with a synchronous flush.
// Revision    : 1.0 - initial release
// ============================================================================
module v850_fetch_queue
    import v850_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_flush,
    input  logic [1:0]               i_push_cnt,
    input  halfword_t                i_push_hw0,
    input  halfword_t                i_push_hw1,
    input  logic [1:0]               i_pop_cnt,
    output halfword_t                o_head0,
    output halfword_t                o_head1,
    output halfword_t                o_head2,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    halfword_t         r_mem [DEPTH];
    logic [PW-1:0]     r_rd;
    logic [PW-1:0]     r_wr;
    logic [CW-1:0]     r_count;

    // Pointer and occupancy bookkeeping; flush empties the queue.
    always_ff @(posedge clk) begin
        if (rst || i_flush) begin
            r_rd    <= '0;
            r_wr    <= '0;
            r_count <= '0;
        end else begin
            r_wr    <= r_wr + PW'(i_push_cnt);
            r_rd    <= r_rd + PW'(i_pop_cnt);
            r_count <= r_count + CW'(i_push_cnt) - CW'(i_pop_cnt);
        end
    end

    // Storage writes; contents need no reset because occupancy gates use.
    always_ff @(posedge clk) begin
        if (!rst && !i_flush) begin
            if (i_push_cnt != 2'd0) begin
                r_mem[r_wr] <= i_push_hw0;
            end
            if (i_push_cnt == 2'd2) begin
                r_mem[r_wr + PW'(1)] <= i_push_hw1;
            end
        end
    end

    assign o_head0 = r_mem[r_rd];
    assign o_head1 = r_mem[r_rd + PW'(1)];
    assign o_head2 = r_mem[r_rd + PW'(2)];
    assign o_count = r_count;

endmodule
`default_nettype wire

// File: rtl/v850_fetch.sv
`default_nettype none
// ============================================================================
// Module      : v850_fetch
// Description : V850 instruction fetch unit. Issues word reads, buffers the
//               returned halfwords, decodes instruction length and hands one
//               complete instruction per cycle to the decoder. Redirects flush
//               queued data and discard in-flight responses.
//               Optional macro V850_LONG48_EN enables 48-bit MOV imm32 decode.
// Revision    : 1.0 - initial release
// ============================================================================
module v850_fetch
    import v850_pkg::*;
#(
    parameter logic [31:0] RESET_PC        = 32'h0000_0000,
    parameter int          QUEUE_HW        = 8,
    parameter int          MAX_OUTSTANDING = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [47:0] inst_data,
    output logic [1:0]  inst_len,
    output logic [31:0] inst_pc,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc
);

    localparam int          CW         = $clog2(QUEUE_HW) + 1;
    localparam int          OW         = $clog2(MAX_OUTSTANDING + 1) + 1;
    localparam logic [31:0] C_RESET_PC = pc_canon(RESET_PC);

    logic           r_mem_req;
    logic [31:0]    r_fetch_addr;
    logic [OW-1:0]  r_outstanding;
    logic [OW-1:0]  r_discard;
    logic           r_skip_low;
    logic [31:0]    r_inst_pc;

    halfword_t      w_head0;
    halfword_t      w_head1;
    halfword_t      w_head2;
    logic [CW-1:0]  w_count;
    inst_len_t      w_len;
    logic           w_valid;
    logic           w_pop;
    logic [1:0]     w_pop_cnt;
    logic           w_grant;
    logic           w_accept;
    logic [1:0]     w_push_cnt;
    halfword_t      w_push_hw0;
    logic [OW-1:0]  w_out_next;
    logic [CW-1:0]  w_count_next;
    logic           w_req_next;
    logic [31:0]    w_redir_pc;

    v850_fetch_queue #(
        .DEPTH (QUEUE_HW)
    ) u_queue (
        .clk        (clk),
        .rst        (rst),
        .i_flush    (redirect_valid),
        .i_push_cnt (w_push_cnt),
        .i_push_hw0 (w_push_hw0),
        .i_push_hw1 (mem_rdata[31:16]),
        .i_pop_cnt  (w_pop_cnt),
        .o_head0    (w_head0),
        .o_head1    (w_head1),
        .o_head2    (w_head2),
        .o_count    (w_count)
    );

    // Decode, handshake, push selection and next-cycle issue decision.
    always_comb begin
        w_redir_pc = pc_canon(redirect_pc);
        w_grant    = r_mem_req & mem_gnt;
        w_len      = (w_count == '0) ? LEN16 : inst_length(w_head0);
        w_valid    = (w_count >= CW'(w_len));
        w_pop      = w_valid & inst_ready & ~redirect_valid;
        w_pop_cnt  = w_pop ? w_len : 2'd0;
        w_accept   = mem_rvalid && (r_discard == '0);
        // The first response after a restart at an odd halfword keeps only
        // its upper halfword.
        w_push_cnt = !w_accept ? 2'd0 : (r_skip_low ? 2'd1 : 2'd2);
        w_push_hw0 = r_skip_low ? mem_rdata[31:16] : mem_rdata[15:0];
        w_out_next = r_outstanding + OW'(w_grant) - OW'(mem_rvalid);
        w_count_next = redirect_valid ? '0
                     : (w_count + CW'(w_push_cnt) - CW'(w_pop_cnt));
        // Each in-flight request reserves two halfwords of queue space.
        w_req_next = (w_out_next < OW'(MAX_OUTSTANDING)) &&
                     ((32'(w_count_next) + 32'd2 * (32'(w_out_next) + 32'd1))
                      <= 32'(QUEUE_HW));
    end

    // Fetch-side and decoder-side control state.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mem_req     <= 1'b0;
            r_fetch_addr  <= {C_RESET_PC[31:2], 2'b00};
            r_outstanding <= '0;
            r_discard     <= '0;
            r_skip_low    <= C_RESET_PC[1];
            r_inst_pc     <= C_RESET_PC;
        end else begin
            r_outstanding <= w_out_next;
            if (redirect_valid) begin
                // Everything still in flight, including a same-cycle grant and
                // excluding a same-cycle response, is now stale.
                r_mem_req    <= 1'b0;
                r_fetch_addr <= {w_redir_pc[31:2], 2'b00};
                r_discard    <= w_out_next;
                r_skip_low   <= w_redir_pc[1];
                r_inst_pc    <= w_redir_pc;
            end else begin
                r_mem_req <= (r_mem_req & ~mem_gnt) | w_req_next;
                if (w_grant) begin
                    r_fetch_addr <= pc_canon(r_fetch_addr + 32'd4);
                end
                if (mem_rvalid && (r_discard != '0)) begin
                    r_discard <= r_discard - OW'(1);
                end
                if (w_accept) begin
                    r_skip_low <= 1'b0;
                end
                if (w_pop) begin
                    r_inst_pc <= pc_canon(r_inst_pc + {29'd0, w_len, 1'b0});
                end
            end
        end
    end

    assign mem_req    = r_mem_req;
    assign mem_addr   = r_fetch_addr;
    assign inst_valid = w_valid;
    assign inst_len   = w_len;
    assign inst_pc    = r_inst_pc;
    assign inst_data[15:0]  = (w_count >= CW'(1)) ? w_head0 : 16'h0000;
    assign inst_data[31:16] = ((w_len != LEN16) && (w_count >= CW'(2))) ? w_head1 : 16'h0000;
    assign inst_data[47:32] = ((w_len == LEN48) && (w_count >= CW'(3))) ? w_head2 : 16'h0000;

endmodule
`default_nettype wire

// File: tb/tb_v850_fetch.sv
`default_nettype none
// ============================================================================
// Module      : tb_v850_fetch
// Description : Self-checking bench for v850_fetch: in-order memory model with
//               1-cycle latency, retirement monitor and directed scenarios.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_v850_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        inst_valid;
    logic        inst_ready;
    logic [47:0] inst_data;
    logic [1:0]  inst_len;
    logic [31:0] inst_pc;
    logic        redirect_valid;
    logic [31:0] redirect_pc;

    always #5 clk = ~clk;

    v850_fetch dut (
        .clk            (clk),
        .rst            (rst),
        .mem_req        (mem_req),
        .mem_addr       (mem_addr),
        .mem_gnt        (mem_gnt),
        .mem_rvalid     (mem_rvalid),
        .mem_rdata      (mem_rdata),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst_data      (inst_data),
        .inst_len       (inst_len),
        .inst_pc        (inst_pc),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc)
    );

    typedef struct {
        logic [31:0] pc;
        logic [1:0]  len;
        logic [47:0] data;
    } rec_t;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] mem [256];
    bit          hold = 1'b0;
    logic [31:0] pend [$];
    logic [31:0] gaddr [$];
    rec_t        ret_q [$];
    rec_t        vt [$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic put_hw(input logic [31:0] addr, input logic [15:0] v);
        if (addr[1]) mem[addr[9:2]][31:16] = v;
        else         mem[addr[9:2]][15:0]  = v;
    endtask

    task automatic cmp_ret(input string tag, input int idx, input logic [31:0] pc,
                           input logic [1:0] len, input logic [47:0] data);
        rec_t r;
        if (idx < ret_q.size()) begin
            r = ret_q[idx];
        end else begin
            r.pc = 'x; r.len = 'x; r.data = 'x;
        end
        check({tag, "_pc"},   64'(r.pc),   64'(pc));
        check({tag, "_len"},  64'(r.len),  64'(len));
        check({tag, "_data"}, 64'(r.data), 64'(data));
    endtask

    task automatic wait_ret(input int n, input string tag);
        for (int c = 0; c < 300 && ret_q.size() < n; c++) @(posedge clk);
        check({tag, "_retired"}, 64'(ret_q.size() >= n), 64'd1);
        step();
    endtask

    task automatic cmp_table(input string tag);
        for (int i = 0; i < vt.size(); i++) begin
            cmp_ret($sformatf("%s_v%0d", tag, i), i, vt[i].pc, vt[i].len, vt[i].data);
        end
    endtask

    task automatic do_reset(input bit check_state);
        step();
        rst = 1'b1;
        repeat (3) step();
        if (check_state) begin
            @(negedge clk);
            check("rst_mem_req",    64'(mem_req),    64'd0);
            check("rst_mem_addr",   64'(mem_addr),   64'd0);
            check("rst_inst_valid", 64'(inst_valid), 64'd0);
            check("rst_inst_data",  64'(inst_data),  64'd0);
            check("rst_inst_len",   64'(inst_len),   64'd1);
            check("rst_inst_pc",    64'(inst_pc),    64'd0);
            step();
        end
        rst = 1'b0;
        ret_q.delete();
        gaddr.delete();
    endtask

    // Memory model: in-order responses one cycle after the grant, unless held.
    initial begin
        logic        g;
        logic [31:0] a;
        logic [31:0] ra;
        mem_rvalid = 1'b0;
        mem_rdata  = '0;
        forever begin
            @(negedge clk);
            g = mem_req && mem_gnt && !rst;
            a = mem_addr;
            if (g) gaddr.push_back(a);
            @(posedge clk);
            #2;
            mem_rvalid = 1'b0;
            if (rst) begin
                pend.delete();
            end else begin
                if (g) pend.push_back(a);
                if (!hold && pend.size() > 0) begin
                    ra         = pend.pop_front();
                    mem_rvalid = 1'b1;
                    mem_rdata  = mem[ra[9:2]];
                end
            end
        end
    end

    // Retirement monitor: every accepted instruction, in order.
    initial begin
        rec_t r;
        forever begin
            @(negedge clk);
            if (!rst && inst_valid && inst_ready && !redirect_valid) begin
                r.pc = inst_pc; r.len = inst_len; r.data = inst_data;
                ret_q.push_back(r);
            end
        end
    end

    initial begin
        logic [31:0] a0;
        bit          ok;
        rst = 1'b1; mem_gnt = 1'b1; inst_ready = 1'b1;
        redirect_valid = 1'b0; redirect_pc = '0;

        // Instruction stream: {pc, expected length, expected data}.
        vt.push_back('{32'd0,  2'd1, 48'h0000_0000_0060});
        vt.push_back('{32'd2,  2'd2, 48'h0000_1234_0E20});
        vt.push_back('{32'd6,  2'd1, 48'h0000_0000_0001});
        vt.push_back('{32'd8,  2'd2, 48'h0000_BEEF_0600});
`ifdef V850_LONG48_EN
        vt.push_back('{32'd12, 2'd3, 48'h9ABC_5678_0620});
`else
        vt.push_back('{32'd12, 2'd2, 48'h0000_5678_0620});
        vt.push_back('{32'd16, 2'd1, 48'h0000_0000_9ABC});
`endif
        vt.push_back('{32'd18, 2'd1, 48'h0000_0000_0200});
        vt.push_back('{32'd20, 2'd1, 48'h0000_0000_0400});
        vt.push_back('{32'd22, 2'd2, 48'h0000_A5A5_FE7F});
        vt.push_back('{32'd26, 2'd1, 48'h0000_0000_1111});

        for (int i = 0; i < 256; i++) mem[i] = '0;
        for (int i = 0; i < vt.size(); i++) begin
            for (int k = 0; k < int'(vt[i].len); k++) begin
                put_hw(vt[i].pc + 32'(2 * k), vt[i].data[16*k +: 16]);
            end
        end
        put_hw(32'h100, 16'h3333);
        put_hw(32'h102, 16'h0044);
        put_hw(32'h104, 16'h0055);

        // Free-running stream with the decoder always ready.
        do_reset(1'b1);
        wait_ret(vt.size(), "run");
        cmp_table("run");
        check("run_gaddr0", 64'(gaddr[0]), 64'h0);
        check("run_gaddr1", 64'(gaddr[1]), 64'h4);
        check("run_gaddr2", 64'(gaddr[2]), 64'h8);
        check("run_gaddr3", 64'(gaddr[3]), 64'hC);

        // Backpressure: queue fills, outputs hold, requests stop.
        inst_ready = 1'b0;
        do_reset(1'b0);
        repeat (6) step();
        ok = 1'b1;
        for (int c = 0; c < 14; c++) begin
            @(negedge clk);
            if (inst_valid !== 1'b1 || inst_pc !== 32'd0 || inst_len !== 2'd1 ||
                inst_data !== 48'h60) ok = 1'b0;
        end
        step();
        check("stall_stable", 64'(ok), 64'd1);
        @(negedge clk);
        check("stall_mem_req", 64'(mem_req), 64'd0);
        check("stall_grants",  64'(gaddr.size()), 64'd4);
        step();
        inst_ready = 1'b1;
        wait_ret(vt.size(), "stall");
        cmp_table("stall");

        // Redirect with two responses still in flight.
        hold = 1'b1;
        do_reset(1'b0);
        for (int c = 0; c < 20 && gaddr.size() < 2; c++) step();
        repeat (2) step();
        check("redir_inflight", 64'(gaddr.size()), 64'd2);
        gaddr.delete();
        ret_q.delete();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0102;
        step();
        redirect_valid = 1'b0;
        hold = 1'b0;
        @(negedge clk);
        check("redir_mem_req",    64'(mem_req),    64'd0);
        check("redir_inst_valid", 64'(inst_valid), 64'd0);
        check("redir_inst_pc",    64'(inst_pc),    64'h102);
        wait_ret(2, "redir");
        check("redir_first_addr", 64'(gaddr[0]), 64'h100);
        cmp_ret("redir_i0", 0, 32'h102, 2'd1, 48'h0044);
        cmp_ret("redir_i1", 1, 32'h104, 2'd1, 48'h0055);

        // Redirect into the upper half of the address space (sign extension).
        ret_q.delete();
        gaddr.delete();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0200_0000;
        step();
        redirect_valid = 1'b0;
        @(negedge clk);
        check("sext_inst_pc",  64'(inst_pc),  64'hFE00_0000);
        check("sext_mem_addr", 64'(mem_addr), 64'hFE00_0000);
        wait_ret(1, "sext");
        cmp_ret("sext_i0", 0, 32'hFE00_0000, 2'd1, 48'h0060);

        // Ungranted request is held stable, then withdrawn by a redirect.
        mem_gnt = 1'b0;
        repeat (12) step();
        @(negedge clk);
        a0 = mem_addr;
        check("hold_req_a", 64'(mem_req), 64'd1);
        repeat (3) step();
        @(negedge clk);
        check("hold_req_b",  64'(mem_req),  64'd1);
        check("hold_addr_b", 64'(mem_addr), 64'(a0));
        step();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0010;
        step();
        redirect_valid = 1'b0;
        @(negedge clk);
        check("wdraw_mem_req",  64'(mem_req),  64'd0);
        check("wdraw_mem_addr", 64'(mem_addr), 64'h10);
        step();
        ret_q.delete();
        mem_gnt = 1'b1;
        wait_ret(1, "wdraw");
        cmp_ret("wdraw_i0", 0, 32'h10, 2'd1, 48'h9ABC);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
